// File: rtl/ysyx_25040109_ifq_pkg.sv
// Shared types and defaults for the instruction fetch queue.
// The IDU uses the same entry layout to unpack what the queue hands over.
//   IFQ_DATA_W / IFQ_PC_W : default instruction / fetch-address widths
//   ifq_entry_t           : {pc, inst, err} at the default widths
//   ifq_entry_w()         : packed entry width for arbitrary widths
package ysyx_25040109_ifq_pkg;

    localparam int unsigned IFQ_DATA_W = 32;
    localparam int unsigned IFQ_PC_W   = 32;

    typedef struct packed {
        logic [IFQ_PC_W-1:0]   pc;
        logic [IFQ_DATA_W-1:0] inst;
        logic                  err;
    } ifq_entry_t;

    function automatic int unsigned ifq_entry_w(int unsigned data_w, int unsigned pc_w);
        return data_w + pc_w + 1;
    endfunction

endpackage

// File: rtl/ysyx_25040109_ifq_ram.sv
// Entry storage for the fetch queue: DEPTH x WIDTH register file.
//   clk   : clock
//   we    : write enable, writes wdata to mem[waddr] on the rising edge
//   waddr : write address
//   wdata : write data
//   raddr : asynchronous read address
//   rdata : asynchronous read data
// Contents are deliberately not reset; the queue pointers decide what is valid.
module ysyx_25040109_ifq_ram #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 65,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ysyx_25040109_fetch_queue.sv
// Instruction fetch queue between instruction memory and the IDU.
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : redirect, drops every queued entry and this cycle's beat
//   mem_valid/rdata/pc/err, ifq_ready_to_mem : memory-side handshake and beat
//   idu_ready, ifq_valid_to_idu, inst_ifq/pc_ifq/err_ifq : IDU-side handshake and head
//   ifq_count           : occupancy
// Memory-side ready depends only on occupancy so memory can keep prefetching
// while the IDU stalls. With BYPASS set, an empty queue hands the incoming beat
// straight to the IDU in the same cycle.
module ysyx_25040109_fetch_queue
    import ysyx_25040109_ifq_pkg::*;
#(
    parameter int unsigned DATA_W = IFQ_DATA_W,
    parameter int unsigned PC_W   = IFQ_PC_W,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned BYPASS = 1,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [PC_W-1:0]   mem_pc,
    input  logic              mem_err,
    output logic              ifq_ready_to_mem,
    input  logic              idu_ready,
    output logic              ifq_valid_to_idu,
    output logic [DATA_W-1:0] inst_ifq,
    output logic [PC_W-1:0]   pc_ifq,
    output logic              err_ifq,
    output logic [CNT_W-1:0]  ifq_count
);

    localparam int unsigned PTR_W     = $clog2(DEPTH);
    localparam int unsigned ENTRY_W   = ifq_entry_w(DATA_W, PC_W);
    localparam bit          BYPASS_EN = (BYPASS != 0);

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               empty, full;
    logic               mem_fire, idu_fire, bypass_hit, push, pop;
    logic [ENTRY_W-1:0] wdata, rdata;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    // No idu_ready term here: a full queue refuses even when the IDU pops.
    assign ifq_ready_to_mem = rst_n && !flush && !full;
    assign mem_fire         = mem_valid && ifq_ready_to_mem;
    assign bypass_hit       = BYPASS_EN && empty && mem_fire;
    assign ifq_valid_to_idu = !flush && (!empty || bypass_hit);
    assign idu_fire         = ifq_valid_to_idu && idu_ready;

    // A bypassed beat consumed in the same cycle never touches the storage.
    assign push = mem_fire && !(bypass_hit && idu_fire);
    assign pop  = idu_fire && !empty;

    assign wdata = {mem_pc, mem_rdata, mem_err};

    ysyx_25040109_ifq_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .AW    (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wdata),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural overflow.
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        pc_ifq   = '0;
        inst_ifq = '0;
        err_ifq  = 1'b0;
        if (!empty) begin
            {pc_ifq, inst_ifq, err_ifq} = rdata;
        end else if (BYPASS_EN) begin
            pc_ifq   = mem_pc;
            inst_ifq = mem_rdata;
            err_ifq  = mem_err;
        end
    end

    assign ifq_count = count_q;

endmodule

// File: tb/tb_ysyx_25040109_fetch_queue.sv
// Bench for the fetch queue: a bypassing (index 0) and a registered (index 1)
// instance share one stimulus stream. The driver pushes every beat it expects
// to be accepted into a per-instance scoreboard; the monitor pops and compares
// whenever the instance delivers a head entry to the IDU.
module tb_ysyx_25040109_fetch_queue;

    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, mem_valid, mem_err, idu_ready;
    logic [31:0] mem_rdata, mem_pc;

    logic        rdy_o  [2];
    logic        vld_o  [2];
    logic        err_o  [2];
    logic [31:0] inst_o [2];
    logic [31:0] pc_o   [2];
    logic [2:0]  cnt_o  [2];

    beat_t sb [2][$];
    bit    jp [2];
    int    errors = 0;
    int    checks = 0;
    int    seq    = 0;

    always #5 clk = ~clk;

    ysyx_25040109_fetch_queue #(.DATA_W(32), .PC_W(32), .DEPTH(DEPTH), .BYPASS(1)) u_byp (
        .clk (clk), .rst_n (rst_n), .flush (flush),
        .mem_valid (mem_valid), .mem_rdata (mem_rdata), .mem_pc (mem_pc), .mem_err (mem_err),
        .ifq_ready_to_mem (rdy_o[0]), .idu_ready (idu_ready), .ifq_valid_to_idu (vld_o[0]),
        .inst_ifq (inst_o[0]), .pc_ifq (pc_o[0]), .err_ifq (err_o[0]), .ifq_count (cnt_o[0])
    );

    ysyx_25040109_fetch_queue #(.DATA_W(32), .PC_W(32), .DEPTH(DEPTH), .BYPASS(0)) u_reg (
        .clk (clk), .rst_n (rst_n), .flush (flush),
        .mem_valid (mem_valid), .mem_rdata (mem_rdata), .mem_pc (mem_pc), .mem_err (mem_err),
        .ifq_ready_to_mem (rdy_o[1]), .idu_ready (idu_ready), .ifq_valid_to_idu (vld_o[1]),
        .inst_ifq (inst_o[1]), .pc_ifq (pc_o[1]), .err_ifq (err_o[1]), .ifq_count (cnt_o[1])
    );

    task automatic chk(input string name, input int i, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, i, got, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; acceptance is decided
    // from the model occupancy, which the monitor last updated on the falling edge.
    task automatic drive(input bit v, input logic [31:0] d_pc, input logic [31:0] d_inst,
                         input bit e, input bit r, input bit fl, input bit rst);
        @(posedge clk);
        #1;
        rst_n     = rst;
        mem_valid = v;
        mem_pc    = d_pc;
        mem_rdata = d_inst;
        mem_err   = e;
        idu_ready = r;
        flush     = fl;
        #2;
        for (int i = 0; i < 2; i++) begin
            if (rst && !fl && v && sb[i].size() < DEPTH) begin
                sb[i].push_back('{d_pc, d_inst, e});
                jp[i] = 1'b1;
            end
        end
    endtask

    task automatic beat(input bit r);
        drive(1'b1, 32'h8000_0000 + 32'(seq) * 4, $urandom, ($urandom_range(7) == 0), r,
              1'b0, 1'b1);
        seq++;
    endtask

    task automatic idle(input int n, input bit r);
        repeat (n) drive(1'b0, 32'h0, 32'h0, 1'b0, r, 1'b0, 1'b1);
    endtask

    always @(negedge clk) begin : monitor
        int    occ;
        int    vis;
        bit    ev;
        beat_t hd;
        for (int i = 0; i < 2; i++) begin
            // occ: entries held before this cycle; vis: entries the IDU can see now.
            occ = sb[i].size() - int'(jp[i]);
            vis = (i == 0) ? sb[i].size() : occ;
            if (!rst_n) begin
                chk("rst_ready", i, 32'(rdy_o[i]), 32'd0);
                chk("rst_valid", i, 32'(vld_o[i]), 32'd0);
                chk("rst_count", i, 32'(cnt_o[i]), 32'd0);
                sb[i].delete();
            end else begin
                chk("ready", i, 32'(rdy_o[i]), 32'(!flush && occ < DEPTH));
                chk("count", i, 32'(cnt_o[i]), 32'(occ));
                ev = !flush && vis > 0;
                chk("valid", i, 32'(vld_o[i]), 32'(ev));
                if (flush) begin
                    sb[i].delete();
                end else if (ev && idu_ready) begin
                    hd = sb[i].pop_front();
                    if (vld_o[i]) begin
                        chk("head_pc", i, pc_o[i], hd.pc);
                        chk("head_inst", i, inst_o[i], hd.inst);
                        chk("head_err", i, 32'(err_o[i]), 32'(hd.err));
                    end
                end
            end
            jp[i] = 1'b0;
        end
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; mem_valid = 1'b0; mem_err = 1'b0;
        idu_ready = 1'b0; mem_pc = '0; mem_rdata = '0;
        repeat (2) drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);

        // Single beat into an empty queue with the IDU ready.
        drive(1'b1, 32'h8000_0000, 32'h0000_0413, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(2, 1'b1);

        // Fill to DEPTH with the IDU stalled, offer a fifth beat, then drain.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h8000_0000 + 32'(k) * 4, $urandom, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        repeat (2) drive(1'b1, 32'h8000_0010, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h8000_0010, 32'h0000_0013, 1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 32'h8000_0010, 32'h0000_0013, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(6, 1'b1);

        // Two entries resident, then simultaneous push and pop across the wrap.
        seq = 100;
        repeat (2) beat(1'b0);
        repeat (6) beat(1'b1);
        idle(4, 1'b1);

        // Flush with three entries queued and a beat on offer.
        repeat (3) beat(1'b0);
        drive(1'b1, 32'h9000_0000, 32'hbad0_bad0, 1'b0, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 32'h9000_0100, 32'h0000_0493, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(2, 1'b1);

        // Faulting beat travels as ordinary data.
        drive(1'b1, 32'h8000_0200, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 32'h8000_0204, 32'h0010_0073, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(3, 1'b1);

        // Randomized phases: balanced, IDU-starved, memory-starved, with flushes.
        seq = 1000;
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 400; c++) begin
                drive(($urandom_range(99) < (p == 2 ? 30 : 75)),
                      32'h8000_0000 + 32'(seq) * 4, $urandom, ($urandom_range(7) == 0),
                      ($urandom_range(99) < (p == 1 ? 25 : 70)),
                      ($urandom_range(99) < 3), 1'b1);
                seq++;
            end
        end

        // Asynchronous reset with three entries queued.
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) beat(1'b0);
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("async_rst_count", i, 32'(cnt_o[i]), 32'd0);
            chk("async_rst_ready", i, 32'(rdy_o[i]), 32'd0);
            chk("async_rst_valid", i, 32'(vld_o[i]), 32'd0);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1);
        repeat (3) beat(1'b1);
        idle(3, 1'b1);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
